lipsi_out_port: RTL and testbench
=================================

Name: lipsi_out_port

Overview:
- Output side of the LIPSI accumulator datapath.
- On an OUT instruction the core presents the accumulator value with a write strobe. This block buffers it in a small FIFO and serialises it onto a UART line (8N1, LSB first).
- Decouples the single-cycle core from the slow serial line. Gives the core a full flag to stall on.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit; legal range 2..255.
- FIFO_DEPTH, 4, FIFO entries; power of two, 2..16.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous reset, active low.
- wr_en  input  1  write strobe from core (OUT instruction).
- wr_data  input  8  accumulator value to transmit.
- clr_ovf  input  1  synchronous clear of the overflow flag.
- full  output  1  FIFO full; core must stall OUT while high.
- level  output  $clog2(FIFO_DEPTH)+1  entries currently stored.
- busy  output  1  high while a frame is in progress (FSM not IDLE).
- overflow  output  1  sticky; set when a write is dropped.
- tx  output  1  serial line; idle high; registered output.

Behaviour:
Reset
- reset_n low asynchronously forces: tx=1, busy=0, full=0, level=0, overflow=0, FSM=IDLE, FIFO pointers=0, bit/baud counters=0.
- Reset asserted mid-frame aborts the frame immediately; tx returns high.
- FIFO contents are discarded on reset.

FIFO
- Circular buffer with read/write pointers and a level counter.
- full = (level==FIFO_DEPTH). Registered, derived from the level register.
- Write accepted when wr_en=1 and full=0 at the clock edge.
- wr_en=1 with full=1 drops the data and sets overflow. This holds even if a pop occurs on the same edge; full is judged on the pre-edge state.
- Simultaneous accepted write and pop: level unchanged; both pointers advance.
- Pointers wrap modulo FIFO_DEPTH.

Overflow flag
- Set has priority over clr_ovf on the same edge.

FSM states: IDLE, START, DATA, STOP.
- IDLE: tx=1. If level>0 at an edge: pop head into 8-bit shift register, zero the baud counter, go to START.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit; shift right after each bit. After bit 7, go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles. At the end, if level>0, pop and go directly to START (no idle gap between frames); else go to IDLE.

Timing
- Frame length is exactly 10*CLKS_PER_BIT cycles.
- Latency: write accepted at edge E0 into an empty FIFO with FSM in IDLE → FSM pops at edge E1. tx goes low in the cycle after E1 (two cycles after wr_en was presented).
- busy is high from the START-entry edge until the edge returning to IDLE.
- level includes only FIFO entries, not the byte in the shift register.

Test Plan:
- Reset: hold reset_n=0, toggle inputs → tx=1, busy=0, level=0, full=0, overflow=0. Release → tx stays 1 with no writes.
- Single byte, CLKS_PER_BIT=4: write 0xA5 → tx low 2 cycles after strobe. Bits sampled mid-bit = 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop). busy high for exactly 40 cycles.
- Back-to-back: write 0x01,0x80,0xFF on consecutive cycles → three frames with no idle cycles between stop and next start. level sequence after writes = 1, then 1 (first popped), then 2.
- Overflow, DEPTH=4: write 6 bytes consecutively while first frame runs (one pop occurs) → 5 accepted, 6th dropped, full=1, overflow=1. Pulse clr_ovf → overflow=0.
- Simultaneous events: with FIFO full, assert wr_en on the same edge as a STOP→START pop → write dropped, overflow set, level=DEPTH-1. Assert clr_ovf together with a dropped write → overflow stays 1.
- Reset mid-frame: assert reset_n=0 during DATA bit 3 → tx=1 immediately, level=0. After release, new write 0x3C transmits a full, correct frame.

Source files
------------

// File: rtl/lipsi_out_port.sv
// LIPSI output port: buffers accumulator bytes from OUT instructions in a small
// FIFO and serialises them onto an 8N1 UART line, LSB first.
module lipsi_out_port #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  input  logic                          clr_ovf,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          busy,
  output logic                          overflow,
  output logic                          tx
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);
  localparam logic [7:0]    BAUD_LAST  = 8'(CLKS_PER_BIT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level_next;
  logic [1:0]    state;
  logic [7:0]    baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          push, pop, baud_done;

  assign baud_done = (baud_cnt == BAUD_LAST);
  assign push      = wr_en && !full;
  // The FSM takes the next byte from IDLE, or straight out of STOP so frames abut.
  assign pop       = (level != '0) &&
                     ((state == S_IDLE) || ((state == S_STOP) && baud_done));
  assign busy      = (state != S_IDLE);

  // NOTE: the storage array has no reset; its contents are meaningless until
  // written, and the pointers/level (which are reset) define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    level_next = level;
    case ({push, pop})
      2'b10:   level_next = level + 1'b1;
      2'b01:   level_next = level - 1'b1;
      default: level_next = level;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level_next;
      full  <= (level_next == LEVEL_FULL);
      // A dropped write wins over a clear arriving on the same edge.
      if (wr_en && full) overflow <= 1'b1;
      else if (clr_ovf)  overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            shift    <= mem[rd_ptr];
            baud_cnt <= '0;
            tx       <= 1'b0;
            state    <= S_START;
          end
        end
        S_START: begin
          if (baud_done) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= shift[0];
            state    <= S_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= S_STOP;
            end else begin
              shift   <= {1'b0, shift[7:1]};
              tx      <= shift[1];
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin // S_STOP
          if (baud_done) begin
            baud_cnt <= '0;
            if (pop) begin
              shift <= mem[rd_ptr];
              tx    <= 1'b0;
              state <= S_START;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lipsi_out_port.sv
// Bench for lipsi_out_port: directed writes feed an expected-byte queue; a
// separate monitor decodes frames on tx and compares them against the queue.
module tb_lipsi_out_port;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       wr_en = 1'b0;
  logic       clr_ovf = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       full, busy, overflow, tx;
  logic [2:0] level;

  int         n_vec = 0;
  int         n_fail = 0;
  logic [7:0] exp_q[$];
  bit         mon_active = 1'b0;

  lipsi_out_port #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_data(wr_data),
    .clr_ovf(clr_ovf), .full(full), .level(level), .busy(busy),
    .overflow(overflow), .tx(tx)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Inputs change on the falling edge; the task returns at the next falling edge.
  task automatic cyc(input bit we, input logic [7:0] d, input bit clr);
    wr_en = we; wr_data = d; clr_ovf = clr;
    @(posedge clk);
    @(negedge clk);
    wr_en = 1'b0; clr_ovf = 1'b0;
  endtask

  task automatic wr_ok(input logic [7:0] d);
    exp_q.push_back(d);
    cyc(1'b1, d, 1'b0);
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_drain();
    int i;
    i = 0;
    while ((busy !== 1'b0 || mon_active || level !== 3'd0) && i < 2000) begin
      @(negedge clk);
      i++;
    end
    check("drain_in_time", 32'(i < 2000), 32'd1);
  endtask

  // Frame monitor: start detected at the first low sample, then one sample per
  // bit half-way through it; bits shift in so bits[0]=start, bits[9]=stop.
  initial begin : monitor
    int         cnt;
    int         k;
    logic [9:0] bits;
    logic [7:0] exp_b;
    cnt = 0; k = 0; bits = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        mon_active = 1'b0;
        cnt = 0;
      end else if (!mon_active) begin
        if (tx === 1'b0) begin
          mon_active = 1'b1;
          cnt = 0; k = 0; bits = '0;
        end
      end else begin
        cnt++;
      end
      if (mon_active && (cnt % CPB) == CPB / 2) begin
        bits = {tx, bits[9:1]};
        k++;
        if (k == 10) begin
          mon_active = 1'b0;
          check("frame_start_bit", 32'(bits[0]), 32'd0);
          check("frame_stop_bit", 32'(bits[9]), 32'd1);
          if (exp_q.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL frame_unexpected: got %0h expected no frame", bits[8:1]);
          end else begin
            exp_b = exp_q.pop_front();
            check("frame_data", 32'(bits[8:1]), 32'(exp_b));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int n;
    // Reset held while inputs toggle
    reset_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      wr_en = ~wr_en; wr_data = 8'h5A; clr_ovf = ~clr_ovf;
    end
    @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    wr_en = 1'b0; clr_ovf = 1'b0; reset_n = 1'b1;
    repeat (5) cyc(1'b0, 8'h00, 1'b0);
    check("post_rst_tx", 32'(tx), 32'd1);
    check("post_rst_busy", 32'(busy), 32'd0);

    // Single byte: start bit appears two cycles after the strobe, 40-cycle frame
    wr_ok(8'hA5);
    check("single_level_e0", 32'(level), 32'd1);
    check("single_tx_e0", 32'(tx), 32'd1);
    check("single_busy_e0", 32'(busy), 32'd0);
    cyc(1'b0, 8'h00, 1'b0);
    check("single_tx_low_e1", 32'(tx), 32'd0);
    check("single_busy_e1", 32'(busy), 32'd1);
    check("single_level_e1", 32'(level), 32'd0);
    count_busy(n);
    check("single_busy_cycles", 32'(n), 32'd40);
    check("single_tx_idle", 32'(tx), 32'd1);

    // Back-to-back: three abutting frames, busy never drops between them
    wr_ok(8'h01);
    check("b2b_level_1", 32'(level), 32'd1);
    wr_ok(8'h80);
    check("b2b_level_2", 32'(level), 32'd1);
    wr_ok(8'hFF);
    check("b2b_level_3", 32'(level), 32'd2);
    count_busy(n);
    check("b2b_busy_cycles", 32'(n), 32'd119);

    // Overflow: 5 accepted (one popped at the second edge), 6th dropped
    wr_ok(8'h11);
    wr_ok(8'h22);
    wr_ok(8'h33);
    wr_ok(8'h44);
    wr_ok(8'h55);
    cyc(1'b1, 8'h66, 1'b0);
    check("ovf_level", 32'(level), 32'd4);
    check("ovf_full", 32'(full), 32'd1);
    check("ovf_flag", 32'(overflow), 32'd1);
    cyc(1'b0, 8'h00, 1'b1);
    check("ovf_cleared", 32'(overflow), 32'd0);
    check("ovf_still_full", 32'(full), 32'd1);

    // Write on the STOP->START pop edge while full: judged on pre-edge full
    repeat (34) cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b1, 8'h77, 1'b0);
    check("simul_level", 32'(level), 32'(DEPTH - 1));
    check("simul_overflow", 32'(overflow), 32'd1);
    check("simul_full", 32'(full), 32'd0);
    check("simul_tx_start", 32'(tx), 32'd0);
    check("simul_busy", 32'(busy), 32'd1);
    wr_ok(8'h88);
    check("refill_full", 32'(full), 32'd1);
    cyc(1'b1, 8'h99, 1'b1);
    check("set_beats_clr", 32'(overflow), 32'd1);
    check("set_beats_clr_level", 32'(level), 32'd4);
    cyc(1'b0, 8'h00, 1'b1);
    check("clr_after", 32'(overflow), 32'd0);

    // Reset during data bit 3 of 0x22 (that bit is 0 on the line)
    repeat (14) cyc(1'b0, 8'h00, 1'b0);
    check("midframe_bit3", 32'(tx), 32'd0);
    reset_n = 1'b0;
    #1;
    check("midrst_tx", 32'(tx), 32'd1);
    check("midrst_level", 32'(level), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_full", 32'(full), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) cyc(1'b0, 8'h00, 1'b0);
    check("midrst_idle_tx", 32'(tx), 32'd1);
    wr_ok(8'h3C);
    wait_drain();
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
